video_fb_stream_output: RTL and testbench

Next-generation framebuffer scan-out stage. It contains its own raster timing generator and a parametrised pixel prefetch FIFO fed by the framebuffer controller through a valid/ready stream. It adds selectable output modes (framebuffer, colour bars, solid colour) and sticky underflow detection with a counter. It sits between the framebuffer controller and the video encoder/PHY, and all of its logic runs on pixel_clock.

---
 rtl/video_fb_pkg.sv | 34 +++
 rtl/video_pix_fifo.sv | 64 ++++++
 rtl/video_fb_stream_output.sv | 187 ++++++++++++++++++
 tb/tb_video_fb_stream_output.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/video_fb_pkg.sv
// Shared definitions for the framebuffer scan-out stage: output modes,
// raster range helpers and the colour-bar table.
package video_fb_pkg;

  localparam logic [1:0] FB_MODE_FB    = 2'd0;
  localparam logic [1:0] FB_MODE_BARS  = 2'd1;
  localparam logic [1:0] FB_MODE_SOLID = 2'd2;

  function automatic int range_start(input int sync_len, input int bp_len);
    return sync_len + bp_len;
  endfunction

  function automatic int range_end(input int sync_len, input int bp_len, input int visible);
    return sync_len + bp_len + visible;
  endfunction

  // Each channel of a bar is all-ones or zero, so the table stores {r,g,b} flags
  // and the consumer replicates each flag across its channel width.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_pix_fifo.sv
// Show-ahead pixel prefetch FIFO with synchronous flush; dout is the head entry
// combinationally. Pushes while full and pops while empty are ignored.
module video_pix_fifo #(
  parameter int width = 24,
  parameter int depth = 16
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(depth));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;

  always_ff @(posedge pixel_clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_fb_stream_output.sv
// Framebuffer scan-out: raster timing, prefetch FIFO, mode mux and underflow
// tracking. One cycle from counters to outputs; fbc_ready drops when full or on line 0.
module video_fb_stream_output
  import video_fb_pkg::*;
#(
  parameter int   video_hlength   = 2200,
  parameter int   video_vlength   = 1125,
  parameter logic video_hsync_pol = 1'b1,
  parameter int   video_hsync_len = 44,
  parameter int   video_hbp_len   = 88,
  parameter int   video_h_visible = 1920,
  parameter logic video_vsync_pol = 1'b1,
  parameter int   video_vsync_len = 5,
  parameter int   video_vbp_len   = 4,
  parameter int   video_v_visible = 1080,
  parameter int   pix_w           = 24,
  parameter int   fifo_depth      = 16
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic [1:0]       cfg_mode,
  input  logic [pix_w-1:0] cfg_blank_color,
  input  logic             underflow_clr,
  output logic             fbc_vsync,
  input  logic             fbc_valid,
  input  logic [pix_w-1:0] fbc_data,
  output logic             fbc_ready,
  output logic             video_vsync,
  output logic             video_hsync,
  output logic             video_den,
  output logic             video_line_start,
  output logic [pix_w-1:0] video_data,
  output logic             underflow,
  output logic [15:0]      underflow_cnt
);

  localparam int HW      = $clog2(video_hlength + 1);
  localparam int VW      = $clog2(video_vlength + 1);
  localparam int BW      = $clog2(video_h_visible + 8) + 1;
  localparam int CH_W    = pix_w / 3;
  localparam int H_START = range_start(video_hsync_len, video_hbp_len);
  localparam int H_END   = range_end(video_hsync_len, video_hbp_len, video_h_visible);
  localparam int V_START = range_start(video_vsync_len, video_vbp_len);
  localparam int V_END   = range_end(video_vsync_len, video_vbp_len, video_v_visible);

  logic [HW-1:0]    h_pos;
  logic [VW-1:0]    v_pos;
  logic             hs_int;
  logic             vs_int;
  logic             hv;
  logic             vv;
  logic             den_int;
  logic             ls_int;
  logic [1:0]       mode_q;
  logic [2:0]       bar_idx;
  logic [BW-1:0]    bar_acc;
  logic [BW-1:0]    bar_acc_sum;
  logic [2:0]       bar_flags;
  logic [pix_w-1:0] bar_pix;
  logic [pix_w-1:0] pix_sel;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [pix_w-1:0] fifo_dout;
  logic             uf_evt;

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      h_pos <= '0;
      v_pos <= '0;
    end else if (h_pos == HW'(video_hlength - 1)) begin
      h_pos <= '0;
      v_pos <= (v_pos == VW'(video_vlength - 1)) ? '0 : v_pos + 1'b1;
    end else begin
      h_pos <= h_pos + 1'b1;
    end
  end

  assign hs_int  = (h_pos < HW'(video_hsync_len));
  assign vs_int  = (v_pos < VW'(video_vsync_len));
  assign hv      = (h_pos >= HW'(H_START)) && (h_pos < HW'(H_END));
  assign vv      = (v_pos >= VW'(V_START)) && (v_pos < VW'(V_END));
  assign den_int = hv && vv;
  assign ls_int  = vv && (h_pos == HW'(H_START));

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      mode_q <= FB_MODE_FB;
    end else if ((h_pos == '0) && (v_pos == '0)) begin
      mode_q <= cfg_mode;
    end
  end

  // Bar index tracks (x*8)/h_visible incrementally: bar_acc holds (x*8) mod h_visible.
  // A single carry per pixel is enough as long as h_visible is at least 8.
  assign bar_acc_sum = bar_acc + BW'(8);

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      bar_idx <= '0;
      bar_acc <= '0;
    end else if (!hv) begin
      bar_idx <= '0;
      bar_acc <= '0;
    end else if (bar_acc_sum >= BW'(video_h_visible)) begin
      bar_idx <= bar_idx + 1'b1;
      bar_acc <= bar_acc_sum - BW'(video_h_visible);
    end else begin
      bar_acc <= bar_acc_sum;
    end
  end

  assign bar_flags = bar_rgb(bar_idx);
  assign bar_pix   = {{CH_W{bar_flags[2]}}, {CH_W{bar_flags[1]}}, {CH_W{bar_flags[0]}}};

  // Line 0 keeps the FIFO flushed so every frame starts from the controller's first pixel.
  assign fifo_flush = (v_pos == '0);
  assign fbc_ready  = !fifo_full && !fifo_flush;
  assign fifo_push  = fbc_valid && fbc_ready;
  assign fifo_pop   = den_int && (mode_q == FB_MODE_FB) && !fifo_empty;
  assign uf_evt     = den_int && (mode_q == FB_MODE_FB) && fifo_empty;

  video_pix_fifo #(
    .width (pix_w),
    .depth (fifo_depth)
  ) u_fifo (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .flush       (fifo_flush),
    .push        (fifo_push),
    .din         (fbc_data),
    .pop         (fifo_pop),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_comb begin
    pix_sel = '0;
    if (den_int) begin
      case (mode_q)
        FB_MODE_FB:   pix_sel = fifo_empty ? cfg_blank_color : fifo_dout;
        FB_MODE_BARS: pix_sel = bar_pix;
        default:      pix_sel = cfg_blank_color;
      endcase
    end
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      video_hsync      <= ~video_hsync_pol;
      video_vsync      <= ~video_vsync_pol;
      video_den        <= 1'b0;
      video_line_start <= 1'b0;
      fbc_vsync        <= 1'b0;
      video_data       <= '0;
    end else begin
      video_hsync      <= hs_int ? video_hsync_pol : ~video_hsync_pol;
      video_vsync      <= vs_int ? video_vsync_pol : ~video_vsync_pol;
      video_den        <= den_int;
      video_line_start <= ls_int;
      fbc_vsync        <= fifo_flush;
      video_data       <= pix_sel;
    end
  end

  // A clear coinciding with an underflow pixel still records that pixel.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (uf_evt) begin
      underflow <= 1'b1;
      if (underflow_clr) begin
        underflow_cnt <= 16'd1;
      end else if (underflow_cnt != 16'hFFFF) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end else if (underflow_clr) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_video_fb_stream_output.sv
// Directed bench on a 16x8 raster with a per-cycle scoreboard and a FIFO occupancy model.
module tb_video_fb_stream_output;

  localparam int HL = 16, VL = 8, HS = 2, HBP = 2, HV = 8, VS = 1, VBP = 1, VV = 4;
  localparam int HST = HS + HBP, VST = VS + VBP;

  typedef struct {
    logic        hs, vs, den, ls, fv, uf;
    logic [23:0] data;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_blank_color;
  logic        underflow_clr;
  logic        fbc_vsync, fbc_valid, fbc_ready;
  logic [23:0] fbc_data;
  logic        video_vsync, video_hsync, video_den, video_line_start;
  logic [23:0] video_data;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [23:0] mq[$];
  int          th, tv;
  logic [1:0]  m_mode;
  logic        m_uf;
  logic [15:0] m_cnt;
  logic [23:0] prod;
  logic        uf_frame, clr_first;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  video_fb_stream_output #(
    .video_hlength(HL), .video_vlength(VL), .video_hsync_pol(1'b1),
    .video_hsync_len(HS), .video_hbp_len(HBP), .video_h_visible(HV),
    .video_vsync_pol(1'b1), .video_vsync_len(VS), .video_vbp_len(VBP),
    .video_v_visible(VV), .pix_w(24), .fifo_depth(16)
  ) dut (
    .pixel_clock(clk), .reset(rst_n), .cfg_mode(cfg_mode),
    .cfg_blank_color(cfg_blank_color), .underflow_clr(underflow_clr),
    .fbc_vsync(fbc_vsync), .fbc_valid(fbc_valid), .fbc_data(fbc_data),
    .fbc_ready(fbc_ready), .video_vsync(video_vsync), .video_hsync(video_hsync),
    .video_den(video_den), .video_line_start(video_line_start),
    .video_data(video_data), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_hsync"}, video_hsync, 0);
    chk({tag, "_vsync"}, video_vsync, 0);
    chk({tag, "_den"}, video_den, 0);
    chk({tag, "_ls"}, video_line_start, 0);
    chk({tag, "_fbc_vsync"}, fbc_vsync, 0);
    chk({tag, "_fbc_ready"}, fbc_ready, 0);
    chk({tag, "_data"}, video_data, 0);
    chk({tag, "_uf"}, underflow, 0);
    chk({tag, "_uf_cnt"}, underflow_cnt, 0);
    chk({tag, "_fifo_empty"}, dut.u_fifo.empty, 1);
  endtask

  // One raster cycle: check the previous cycle's outputs, drive inputs, predict this cycle.
  task automatic step();
    exp_t        e;
    exp_t        o;
    logic        rdy, den, evt;
    logic [2:0]  bi;
    logic [23:0] pix;
    if (sb.size() > 0) begin
      o = sb.pop_front();
      chk("hsync", video_hsync, o.hs);
      chk("vsync", video_vsync, o.vs);
      chk("den", video_den, o.den);
      chk("line_start", video_line_start, o.ls);
      chk("fbc_vsync", fbc_vsync, o.fv);
      chk("data", video_data, o.data);
      chk("underflow", underflow, o.uf);
      chk("underflow_cnt", underflow_cnt, o.cnt);
    end
    if (tv == 0) prod = 24'd1;
    fbc_data      = prod;
    fbc_valid     = !(uf_frame && (tv == 1 || (tv == 2 && th < 6)));
    underflow_clr = clr_first && tv == 2 && th == HST;
    if (th == 0 && tv == 0) m_mode = cfg_mode;
    rdy = (tv != 0) && (mq.size() < 16);
    chk("fbc_ready", fbc_ready, rdy);
    den = (th >= HST && th < HST + HV) && (tv >= VST && tv < VST + VV);
    pix = 24'd0;
    evt = 1'b0;
    if (den) begin
      case (m_mode)
        2'd0: begin
          if (mq.size() == 0) begin
            pix = cfg_blank_color;
            evt = 1'b1;
          end else begin
            pix = mq.pop_front();
          end
        end
        2'd1: begin
          bi  = 3'(((th - HST) * 8) / HV);
          pix = bars[bi];
        end
        default: pix = cfg_blank_color;
      endcase
    end
    if (tv == 0) begin
      mq.delete();
    end else if (fbc_valid && rdy) begin
      mq.push_back(prod);
      prod = prod + 24'd1;
    end
    if (evt) begin
      m_uf  = 1'b1;
      m_cnt = underflow_clr ? 16'd1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1);
    end else if (underflow_clr) begin
      m_uf  = 1'b0;
      m_cnt = 16'd0;
    end
    e.hs   = (th < HS);
    e.vs   = (tv < VS);
    e.den  = den;
    e.ls   = (tv >= VST && tv < VST + VV) && (th == HST);
    e.fv   = (tv == 0);
    e.data = pix;
    e.uf   = m_uf;
    e.cnt  = m_cnt;
    sb.push_back(e);
    th++;
    if (th == HL) begin
      th = 0;
      tv = (tv == VL - 1) ? 0 : tv + 1;
    end
  endtask

  task automatic tick();
    step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    mq.delete();
    th = 0; tv = 0; m_mode = 2'd0; m_uf = 1'b0; m_cnt = 16'd0; prod = 24'd1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_mode = 2'd0; cfg_blank_color = 24'h123456; underflow_clr = 1'b0;
    fbc_valid = 1'b0; fbc_data = 24'd0; uf_frame = 1'b0; clr_first = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;

    // Two clean frames in framebuffer mode: contiguous data restarting at 1.
    repeat (2 * HL * VL) tick();

    // Producer stalls until mid line 2: three underflow pixels.
    uf_frame = 1'b1;
    repeat (HL * VL) tick();
    chk("uf_flag_after_stall", underflow, 1);
    chk("uf_cnt_after_stall", underflow_cnt, 3);

    // Same stall with a clear on the first underflow pixel.
    clr_first = 1'b1;
    repeat (2 * HL + HST + 1) tick();
    chk("uf_cnt_clr_collide", underflow_cnt, 1);
    chk("uf_flag_clr_collide", underflow, 1);
    repeat (HL * VL - (2 * HL + HST + 1)) tick();
    chk("uf_cnt_after_clr_frame", underflow_cnt, 3);

    // Colour bars, then a mid-frame switch to solid that waits for the next frame.
    uf_frame = 1'b0; clr_first = 1'b0; cfg_mode = 2'd1;
    repeat (HL * VL) tick();
    repeat (3 * HL) tick();
    cfg_mode = 2'd2;
    repeat (HL * VL - 3 * HL) tick();
    repeat (HL * VL) tick();

    // Mid-line reset with the FIFO full.
    repeat (2 * HL + 2) tick();
    chk("fifo_full_before_reset", dut.u_fifo.full, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("mid");
    cfg_mode = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (HL * VL) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
